// File: rtl/vec_exec_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_exec_seq_pkg
//  Description : Shared opcodes, FSM states, default sizes and width helper
//                for the multi-lane vector execute sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package vec_exec_seq_pkg;

   // Default geometry
   localparam int VEC_ELEN_DEF  = 32;
   localparam int VEC_LANES_DEF = 4;
   localparam int VEC_MAXVL_DEF = 16;
   localparam int VEC_NREG_DEF  = 8;

   // Element opcodes
   localparam logic [2:0] VOP_ADD = 3'd0;
   localparam logic [2:0] VOP_SUB = 3'd1;
   localparam logic [2:0] VOP_AND = 3'd2;
   localparam logic [2:0] VOP_OR  = 3'd3;
   localparam logic [2:0] VOP_XOR = 3'd4;
   localparam logic [2:0] VOP_MUL = 3'd5;
   localparam logic [2:0] VOP_SLL = 3'd6;
   localparam logic [2:0] VOP_SRL = 3'd7;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ZERO  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   // Group-index width: at least one bit even when a single group covers MAXVL
   function automatic int grp_width(input int maxvl, input int lanes);
      return ((maxvl / lanes) > 1) ? $clog2(maxvl / lanes) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vec_exec_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : vec_issue_if / vec_vrf_if
//  Description : Issue handshake bundle (decode -> sequencer) and vector
//                register-file access bundle (sequencer -> register file).
//  Revision    : 1.0 - initial release
// ============================================================================
interface vec_issue_if #(
   parameter int ELEN  = 32,
   parameter int REG_W = 3,
   parameter int VL_W  = 5
);
   logic             valid;
   logic             ready;
   logic [2:0]       op;
   logic             vx;
   logic [ELEN-1:0]  scalar;
   logic [REG_W-1:0] vs1;
   logic [REG_W-1:0] vs2;
   logic [REG_W-1:0] vd;
   logic [VL_W-1:0]  vl;

   // master = instruction source, slave = sequencer
   modport master (output valid, op, vx, scalar, vs1, vs2, vd, vl, input ready);
   modport slave  (input valid, op, vx, scalar, vs1, vs2, vd, vl, output ready);
endinterface

interface vec_vrf_if #(
   parameter int ELEN  = 32,
   parameter int LANES = 4,
   parameter int REG_W = 3,
   parameter int GRP_W = 2
);
   logic                    rd_en;
   logic [REG_W-1:0]        rd_vs1;
   logic [REG_W-1:0]        rd_vs2;
   logic [GRP_W-1:0]        rd_grp;
   logic [LANES*ELEN-1:0]   rd_data1;
   logic [LANES*ELEN-1:0]   rd_data2;
   logic                    wr_en;
   logic [REG_W-1:0]        wr_vd;
   logic [GRP_W-1:0]        wr_grp;
   logic [LANES*ELEN-1:0]   wr_data;
   logic [LANES-1:0]        wr_mask;

   // master = sequencer, slave = register file
   modport master (output rd_en, rd_vs1, rd_vs2, rd_grp, wr_en, wr_vd, wr_grp, wr_data, wr_mask,
                   input  rd_data1, rd_data2);
   modport slave  (input  rd_en, rd_vs1, rd_vs2, rd_grp, wr_en, wr_vd, wr_grp, wr_data, wr_mask,
                   output rd_data1, rd_data2);
endinterface
`default_nettype wire

// File: rtl/vec_exec_seq_lane_alu.sv
`default_nettype none
// ============================================================================
//  Module      : vec_lane_alu
//  Description : One ELEN-wide combinational element ALU. Wrap-around
//                arithmetic, low half of unsigned product, logical shifts
//                by the low clog2(ELEN) bits of b.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_lane_alu
   import vec_exec_seq_pkg::*;
#(
   parameter int ELEN = VEC_ELEN_DEF
) (
   input  wire logic [2:0]      op_i,
   input  wire logic [ELEN-1:0] a_i,
   input  wire logic [ELEN-1:0] b_i,
   output logic      [ELEN-1:0] y_o
);

   localparam int SH_W = (ELEN > 1) ? $clog2(ELEN) : 1;

   logic [SH_W-1:0] sh_w;
   assign sh_w = b_i[SH_W-1:0];

   // Element operation select
   always_comb begin
      y_o = '0;
      case (op_i)
         VOP_ADD: y_o = a_i + b_i;
         VOP_SUB: y_o = a_i - b_i;
         VOP_AND: y_o = a_i & b_i;
         VOP_OR:  y_o = a_i | b_i;
         VOP_XOR: y_o = a_i ^ b_i;
         VOP_MUL: y_o = a_i * b_i;
         VOP_SLL: y_o = a_i << sh_w;
         VOP_SRL: y_o = a_i >> sh_w;
         default: y_o = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/vec_exec_seq.sv
`default_nettype none
// ============================================================================
//  Module      : vec_exec_seq
//  Description : Multi-lane vector execute sequencer. Accepts one vector
//                instruction, strip-mines it over ceil(vl/LANES) groups via a
//                read / compute / write pipeline, masks tail lanes and pulses
//                done_o with the final write.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_exec_seq
   import vec_exec_seq_pkg::*;
#(
   parameter int ELEN  = VEC_ELEN_DEF,
   parameter int LANES = VEC_LANES_DEF,
   parameter int MAXVL = VEC_MAXVL_DEF,
   parameter int NREG  = VEC_NREG_DEF
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   vec_issue_if.slave issue,
   vec_vrf_if.master  vrf,
   output logic       done_o
);

   localparam int GRP_W = grp_width(MAXVL, LANES);
   localparam int REG_W = $clog2(NREG);
   localparam int VL_W  = $clog2(MAXVL + 1);
   localparam int LSB_W = $clog2(LANES);
   localparam int IDX_W = VL_W + 1;

   // Control / latched instruction
   state_e                state_q, state_d;
   logic [2:0]            op_q;
   logic                  vx_q;
   logic [ELEN-1:0]       scalar_q;
   logic [REG_W-1:0]      vs1_q, vs2_q, vd_q;
   logic [VL_W-1:0]       vl_q;
   logic [GRP_W-1:0]      last_grp_q;
   logic [GRP_W-1:0]      grp_q;

   // Read-return stage
   logic                  rd_vld_q;
   logic [GRP_W-1:0]      rd_grp_q;
   logic                  rd_last_q;

   // Write stage
   logic                  wr_en_q;
   logic [GRP_W-1:0]      wr_grp_q;
   logic [LANES-1:0]      wr_mask_q;
   logic [LANES*ELEN-1:0] wr_data_q;
   logic                  wr_last_q;

   logic                  accept_w;
   logic [VL_W-1:0]       vl_eff_w;
   logic [VL_W-1:0]       vl_m1_w;
   logic [GRP_W-1:0]      last_grp_w;
   logic                  rd_last_w;
   logic                  retire_w;
   logic [LANES-1:0]      mask_w;
   logic [LANES*ELEN-1:0] alu_y_w;

   assign accept_w   = issue.valid && (state_q == ST_IDLE);
   assign vl_eff_w   = (issue.vl > VL_W'(MAXVL)) ? VL_W'(MAXVL) : issue.vl;
   assign vl_m1_w    = vl_eff_w - VL_W'(1);
   assign last_grp_w = GRP_W'(vl_m1_w >> LSB_W);
   assign rd_last_w  = (grp_q == last_grp_q);
   assign retire_w   = wr_en_q && wr_last_q;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state: RUN issues reads, DRAIN waits for the final write
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept_w) state_d = (vl_eff_w == '0) ? ST_ZERO : ST_RUN;
         ST_ZERO:  state_d = ST_IDLE;
         ST_RUN:   if (rd_last_w) state_d = ST_DRAIN;
         ST_DRAIN: if (retire_w) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Latch the instruction on accept and step the read group during RUN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_q       <= '0;
         vx_q       <= 1'b0;
         scalar_q   <= '0;
         vs1_q      <= '0;
         vs2_q      <= '0;
         vd_q       <= '0;
         vl_q       <= '0;
         last_grp_q <= '0;
         grp_q      <= '0;
      end else if (accept_w) begin
         op_q       <= issue.op;
         vx_q       <= issue.vx;
         scalar_q   <= issue.scalar;
         vs1_q      <= issue.vs1;
         vs2_q      <= issue.vs2;
         vd_q       <= issue.vd;
         vl_q       <= vl_eff_w;
         last_grp_q <= last_grp_w;
         grp_q      <= '0;
      end else if (state_q == ST_RUN && !rd_last_w) begin
         grp_q      <= grp_q + GRP_W'(1);
      end
   end

   // Tail mask for the group whose data is returning this cycle
   always_comb begin
      mask_w = '0;
      for (int i = 0; i < LANES; i++) begin
         mask_w[i] = (IDX_W'(rd_grp_q) * IDX_W'(LANES) + IDX_W'(i)) < IDX_W'(vl_q);
      end
   end

   // Lane ALUs; operand B is the broadcast scalar in vx mode
   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         logic [ELEN-1:0] b_w;
         assign b_w = vx_q ? scalar_q : vrf.rd_data2[i*ELEN +: ELEN];

         vec_lane_alu #(
            .ELEN (ELEN)
         ) u_alu (
            .op_i (op_q),
            .a_i  (vrf.rd_data1[i*ELEN +: ELEN]),
            .b_i  (b_w),
            .y_o  (alu_y_w[i*ELEN +: ELEN])
         );
      end
   endgenerate

   // Read-return and write pipeline registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_vld_q  <= 1'b0;
         rd_grp_q  <= '0;
         rd_last_q <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_grp_q  <= '0;
         wr_mask_q <= '0;
         wr_data_q <= '0;
         wr_last_q <= 1'b0;
      end else begin
         rd_vld_q  <= (state_q == ST_RUN);
         rd_grp_q  <= grp_q;
         rd_last_q <= rd_last_w;
         wr_en_q   <= rd_vld_q;
         wr_last_q <= rd_vld_q && rd_last_q;
         if (rd_vld_q) begin
            wr_grp_q  <= rd_grp_q;
            wr_mask_q <= mask_w;
            wr_data_q <= alu_y_w;
         end
      end
   end

   assign issue.ready  = (state_q == ST_IDLE);
   assign vrf.rd_en    = (state_q == ST_RUN);
   assign vrf.rd_vs1   = vs1_q;
   assign vrf.rd_vs2   = vs2_q;
   assign vrf.rd_grp   = grp_q;
   assign vrf.wr_en    = wr_en_q;
   assign vrf.wr_vd    = vd_q;
   assign vrf.wr_grp   = wr_grp_q;
   assign vrf.wr_data  = wr_data_q;
   assign vrf.wr_mask  = wr_mask_q;
   assign done_o       = (state_q == ST_ZERO) || retire_w;

endmodule
`default_nettype wire

// File: tb/tb_vec_exec_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_exec_seq
//  Description : Self-checking bench for vec_exec_seq with a behavioural
//                register file and a read/write/done scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_exec_seq;
   import vec_exec_seq_pkg::*;

   localparam int ELEN  = 32;
   localparam int LANES = 4;
   localparam int MAXVL = 16;
   localparam int NREG  = 8;
   localparam int GRP_W = 2;
   localparam int REG_W = 3;
   localparam int VL_W  = 5;
   localparam int DW    = LANES * ELEN;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic done;

   always #5 clk = ~clk;

   vec_issue_if #(.ELEN(ELEN), .REG_W(REG_W), .VL_W(VL_W)) iss ();
   vec_vrf_if   #(.ELEN(ELEN), .LANES(LANES), .REG_W(REG_W), .GRP_W(GRP_W)) vrf ();

   vec_exec_seq #(
      .ELEN  (ELEN),
      .LANES (LANES),
      .MAXVL (MAXVL),
      .NREG  (NREG)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .issue  (iss),
      .vrf    (vrf),
      .done_o (done)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Register-file model: read data one cycle after rd_en, masked writes,
   // and a whole-register preload port driven by the stimulus process
   // ------------------------------------------------------------------
   logic [ELEN-1:0] mem     [NREG][MAXVL];
   logic [ELEN-1:0] ld_vals [MAXVL];
   logic            ld_en  = 1'b0;
   int              ld_reg = 0;

   always @(posedge clk) begin
      if (vrf.rd_en === 1'b1) begin
         for (int i = 0; i < LANES; i++) begin
            vrf.rd_data1[i*ELEN +: ELEN] <= mem[vrf.rd_vs1][int'(vrf.rd_grp)*LANES + i];
            vrf.rd_data2[i*ELEN +: ELEN] <= mem[vrf.rd_vs2][int'(vrf.rd_grp)*LANES + i];
         end
      end
      if (vrf.wr_en === 1'b1) begin
         for (int i = 0; i < LANES; i++)
            if (vrf.wr_mask[i]) mem[vrf.wr_vd][int'(vrf.wr_grp)*LANES + i] = vrf.wr_data[i*ELEN +: ELEN];
      end
      if (ld_en) begin
         for (int e = 0; e < MAXVL; e++) mem[ld_reg][e] = ld_vals[e];
      end
   end

   // mode 0: constant v, 1: index + v, 2: random
   task automatic fill(input int r, input int mode, input logic [ELEN-1:0] v);
      @(negedge clk);
      for (int e = 0; e < MAXVL; e++) begin
         case (mode)
            0:       ld_vals[e] = v;
            1:       ld_vals[e] = v + ELEN'(e);
            default: ld_vals[e] = $urandom;
         endcase
      end
      ld_reg = r;
      ld_en  = 1'b1;
      @(negedge clk);
      ld_en  = 1'b0;
   endtask

   function automatic logic [ELEN-1:0] alu_ref(input logic [2:0] op, input logic [ELEN-1:0] a,
                                               input logic [ELEN-1:0] b);
      logic [2*ELEN-1:0] p;
      int sh;
      sh = int'(b % ELEN);
      p  = {{ELEN{1'b0}}, a} * {{ELEN{1'b0}}, b};
      case (op)
         3'd0:    return a + b;
         3'd1:    return a + ~b + 1;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return p[ELEN-1:0];
         3'd6:    return a << sh;
         default: return a >> sh;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   typedef struct {
      int               rel;
      int               grp;
      logic [REG_W-1:0] vs1;
      logic [REG_W-1:0] vs2;
   } rd_exp_t;

   typedef struct {
      int               rel;
      int               grp;
      logic [REG_W-1:0] vd;
      logic [LANES-1:0] mask;
      logic [DW-1:0]    data;
   } wr_exp_t;

   rd_exp_t rd_q[$];
   wr_exp_t wr_q[$];
   int      done_q[$];
   int      cyc      = 0;
   int      acc_cyc  = 0;
   int      done_rel = 0;
   bit      active   = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic flush_sb();
      rd_q.delete();
      wr_q.delete();
      done_q.delete();
   endtask

   task automatic do_issue(input logic [2:0] op, input bit vx, input logic [ELEN-1:0] sc,
                           input int vs1, input int vs2, input int vd, input int vl,
                           input bit wait_done);
      int      to;
      int      vle;
      int      ng;
      rd_exp_t re;
      wr_exp_t we;
      to = 0;
      do begin
         @(negedge clk);
         to++;
      end while ((active || iss.ready !== 1'b1) && to < 200);
      if (to >= 200) check_val("issue_wait_ready", iss.ready, 1);
      vle = (vl > MAXVL) ? MAXVL : vl;
      ng  = (vle + LANES - 1) / LANES;
      for (int g = 0; g < ng; g++) begin
         re.rel = 1 + g;
         re.grp = g;
         re.vs1 = REG_W'(vs1);
         re.vs2 = REG_W'(vs2);
         rd_q.push_back(re);
         we.rel  = 3 + g;
         we.grp  = g;
         we.vd   = REG_W'(vd);
         we.mask = '0;
         we.data = '0;
         for (int i = 0; i < LANES; i++) begin
            int e;
            e = g * LANES + i;
            we.mask[i] = (e < vle);
            we.data[i*ELEN +: ELEN] = alu_ref(op, mem[vs1][e], vx ? sc : mem[vs2][e]);
         end
         wr_q.push_back(we);
      end
      done_rel = (ng == 0) ? 1 : ng + 2;
      done_q.push_back(done_rel);
      iss.op     = op;
      iss.vx     = vx;
      iss.scalar = sc;
      iss.vs1    = REG_W'(vs1);
      iss.vs2    = REG_W'(vs2);
      iss.vd     = REG_W'(vd);
      iss.vl     = VL_W'(vl);
      iss.valid  = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      active  = 1'b1;
      @(negedge clk);
      iss.valid = 1'b0;
      if (wait_done) begin
         to = 0;
         while (active && to < 100) begin
            @(negedge clk);
            to++;
         end
         if (active) begin
            check_val("retire_timeout", active, 0);
            flush_sb();
            active = 1'b0;
         end
      end
   endtask

   // Monitor: every strobe must match the head of its expectation queue
   always @(negedge clk) begin
      int      rel;
      rd_exp_t re;
      wr_exp_t we;
      int      dr;
      rel = cyc - acc_cyc + 1;
      if (vrf.rd_en !== 1'b0) begin
         if (rd_q.size() == 0) check_val("rd_unexpected", vrf.rd_en, 0);
         else begin
            re = rd_q.pop_front();
            check_val("rd_cycle", rel, re.rel);
            check_val("rd_grp", vrf.rd_grp, re.grp);
            check_val("rd_vs1", vrf.rd_vs1, re.vs1);
            check_val("rd_vs2", vrf.rd_vs2, re.vs2);
         end
      end
      if (vrf.wr_en !== 1'b0) begin
         if (wr_q.size() == 0) check_val("wr_unexpected", vrf.wr_en, 0);
         else begin
            we = wr_q.pop_front();
            check_val("wr_cycle", rel, we.rel);
            check_val("wr_grp", vrf.wr_grp, we.grp);
            check_val("wr_vd", vrf.wr_vd, we.vd);
            check_val("wr_mask", vrf.wr_mask, we.mask);
            check_val("wr_data", vrf.wr_data, we.data);
         end
      end
      if (done !== 1'b0) begin
         if (done_q.size() == 0) check_val("done_unexpected", done, 0);
         else begin
            dr = done_q.pop_front();
            check_val("done_cycle", rel, dr);
         end
      end
      if (active) begin
         if (rel == done_rel + 1) begin
            check_val("ready_after_retire", iss.ready, 1);
            check_val("events_missing", rd_q.size() + wr_q.size() + done_q.size(), 0);
            flush_sb();
            active = 1'b0;
         end else begin
            check_val("ready_while_busy", iss.ready, 0);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      iss.valid  = 1'b0;
      iss.op     = '0;
      iss.vx     = 1'b0;
      iss.scalar = '0;
      iss.vs1    = '0;
      iss.vs2    = '0;
      iss.vd     = '0;
      iss.vl     = '0;
      for (int e = 0; e < MAXVL; e++) ld_vals[e] = '0;
      for (int r = 0; r < NREG; r++)
         for (int e = 0; e < MAXVL; e++) mem[r][e] = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_ready", iss.ready, 1);
      check_val("rst_rd_en", vrf.rd_en, 0);
      check_val("rst_wr_en", vrf.wr_en, 0);
      check_val("rst_done", done, 0);
      check_val("rst_wr_mask", vrf.wr_mask, 0);
      check_val("rst_wr_data", vrf.wr_data, 0);
      rst_n = 1'b1;

      fill(1, 1, 0);                    // v1[e] = e
      fill(2, 0, 100);                  // v2[e] = 100
      fill(4, 0, 32'hFFFF_FFFF);
      fill(0, 0, 0);

      do_issue(VOP_ADD, 0, 0, 1, 2, 3, 16, 1);
      do_issue(VOP_XOR, 0, 0, 1, 4, 5, 6, 1);
      do_issue(VOP_ADD, 0, 0, 1, 2, 6, 0, 1);
      do_issue(VOP_ADD, 0, 0, 1, 2, 6, 20, 1);

      do_issue(VOP_SUB, 1, 32'd1, 0, 2, 7, 4, 1);
      fill(5, 0, 32'h0001_0000);
      do_issue(VOP_MUL, 1, 32'h0001_0000, 5, 2, 7, 4, 1);
      fill(5, 0, 32'd1);
      do_issue(VOP_SLL, 1, 32'd33, 5, 2, 7, 4, 1);
      fill(5, 0, 32'h8000_0000);
      do_issue(VOP_SRL, 1, 32'd31, 5, 2, 7, 4, 1);

      fill(2, 2, 0);
      do_issue(VOP_ADD, 1, 32'd7, 1, 2, 6, 4, 1);
      do_issue(VOP_ADD, 0, 0, 3, 3, 3, 7, 1);
      do_issue(VOP_AND, 0, 0, 1, 4, 1, 9, 1);

      for (int k = 0; k < 8; k++) begin
         fill(1, 2, 0);
         fill(2, 2, 0);
         do_issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(1, 2), $urandom_range(1, 2), $urandom_range(3, 7),
                  $urandom_range(0, 20), 1);
      end

      // Abandon a vl=16 instruction: reset held low through cycle 3
      do_issue(VOP_ADD, 0, 0, 1, 2, 6, 16, 0);
      @(negedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      flush_sb();
      active = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_val("abort_ready", iss.ready, 1);
      check_val("abort_wr_en", vrf.wr_en, 0);
      check_val("abort_done", done, 0);
      check_val("abort_rd_en", vrf.rd_en, 0);
      repeat (6) @(negedge clk);

      fill(1, 1, 0);
      fill(2, 0, 100);
      do_issue(VOP_ADD, 0, 0, 1, 2, 3, 16, 1);
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vec_exec_seq.md
Name: vec_exec_seq

Overview:
- Parametrised multi-lane vector execute sequencer: the execute stage generalised from a single fixed unit to LANES parallel element ALUs.
- Accepts one vector instruction through a valid/ready handshake.
- Strip-mines the instruction over ceil(vl/LANES) element groups using a 3-stage read/compute/write pipeline against the vector register file.
- Masks tail elements and pulses done when the instruction retires. Sits between decode and write_back.

Parameters:
ELEN, 32, element width in bits
LANES, 4, elements processed per cycle (power of 2, 1..16)
MAXVL, 16, maximum vector length (multiple of LANES)
NREG, 8, number of vector registers
(derived) GRP_W = max(1, clog2(MAXVL/LANES)); REG_W = clog2(NREG); VL_W = clog2(MAXVL+1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
issue_valid  in  1  instruction offered
issue_ready  out  1  block idle, can accept
issue_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL(low ELEN), 6 SLL, 7 SRL
issue_vx  in  1  1 = operand B is issue_scalar broadcast to all lanes
issue_scalar  in  ELEN  scalar operand
issue_vs1 / issue_vs2 / issue_vd  in  REG_W each  source and destination registers
issue_vl  in  VL_W  element count
vrf_rd_en  out  1  register-file read strobe
vrf_rd_vs1 / vrf_rd_vs2  out  REG_W  read registers
vrf_rd_grp  out  GRP_W  element group index
vrf_rd_data1 / vrf_rd_data2  in  LANES*ELEN  read data, valid exactly 1 cycle after vrf_rd_en
vrf_wr_en  out  1  write strobe
vrf_wr_vd  out  REG_W  destination register
vrf_wr_grp  out  GRP_W  group index
vrf_wr_data  out  LANES*ELEN  results; lane i occupies bits [i*ELEN +: ELEN]
vrf_wr_mask  out  LANES  per-lane write enable
done  out  1  one-cycle retire pulse

Behaviour:
- Reset values: all outputs 0 except issue_ready = 1. FSM = IDLE. All pipeline valid bits cleared.
- Reset mid-operation: the instruction is abandoned. No rd/wr/done strobe is produced on any cycle after the reset edge.
- Accept: the instruction is accepted on the edge where issue_valid && issue_ready. Operands are latched at that edge. Call that edge cycle 0.
- vl clamp: vl_eff = min(issue_vl, MAXVL). ngrp = ceil(vl_eff/LANES).
- FSM states:
  - IDLE: issue_ready = 1. Accept with ngrp > 0 moves to RUN. Accept with vl_eff = 0 moves to ZERO.
  - ZERO: asserts done for 1 cycle (cycle 1). No reads or writes. Returns to IDLE.
  - RUN: issues one read per cycle, groups 0..ngrp-1, on cycles 1..ngrp. After the last read, moves to DRAIN.
  - DRAIN: waits until the last write has issued, then returns to IDLE.
- Pipeline timing:
  - Read of group g on cycle 1+g.
  - Data returns on cycle 2+g. It passes through the lane ALUs combinationally and is registered.
  - Write of group g on cycle 3+g.
- Retire: done is asserted coincident with the final vrf_wr_en (cycle ngrp+2). The FSM is IDLE and issue_ready = 1 on the next cycle.
- issue_ready stays 0 from the accept edge until retire. Back-to-back instructions therefore have a minimum 1-cycle gap after done.
- Tail mask: vrf_wr_mask[i] = ((g*LANES + i) < vl_eff). Masked lanes still carry ALU output in vrf_wr_data; the register file ignores them.
- Arithmetic: all results are ELEN bits with wrap-around (ADD/SUB modulo 2^ELEN). MUL keeps the low ELEN bits of the unsigned product.
- Shifts: SLL and SRL are logical. Shift amount = B[clog2(ELEN)-1:0].
- Operand B: issue_vx = 1 replaces B with issue_scalar in every lane. vrf_rd_data2 is ignored, but vrf_rd_vs2 is still driven.
- vd equal to vs1 or vs2 is legal. The write of group g never precedes the read of group g, so no hazard exists.

Decomposition:
- Shared package/header vp_defs.v holds:
  - opcode localparams VOP_ADD..VOP_SRL
  - FSM state encodings
  - default ELEN/LANES/MAXVL/NREG
- One sub-module, vec_lane_alu (combinational, one ELEN-wide lane: op, a, b -> y), instantiated LANES times in a generate loop.
- The FSM, group counter, and pipeline registers live in vec_exec_seq.

Test Plan:
- ADD, vl=16, LANES=4, v1 elements = index, v2 elements = 100 -> reads on cycles 1-4; writes on cycles 3-6 with groups 0..3, mask 1111, elements 100..115; done on cycle 6.
- vl=6, XOR with all-ones -> 2 groups; group 1 mask 0011; done on cycle 4; issue_ready high on cycle 5.
- vl=0 -> no vrf_rd_en or vrf_wr_en; done on cycle 1. vl=20 -> clamped to 16, 4 groups.
- Arithmetic boundaries:
  - SUB 0-1 -> 0xFFFFFFFF
  - MUL 0x10000 * 0x10000 -> 0x00000000
  - SLL 1 by 33 -> 2 (shift amount taken mod 32)
  - SRL 0x80000000 by 31 -> 1
- VX mode: ADD with scalar 7, vl=4 -> every lane = v1 + 7, independent of vrf_rd_data2 contents.
- rst_n low on cycle 3 of a vl=16 op -> no writes or done from cycle 4 onward; issue_ready = 1 after reset; the next instruction executes normally.
